// File: rtl/uc_pkg.sv
// -----------------------------------------------------------------------------
// uc_pkg
// Shared constants and types for the unit-clause transmit path.
//   UC_LENGTH  : size of the literal space
//   LIT_W      : literal width in bits
//   lit_t      : signed literal (two's complement, 0 reserved)
//   tx_state_e : transmitter FSM states
// -----------------------------------------------------------------------------
package uc_pkg;

  localparam int UC_LENGTH = 512;
  localparam int LIT_W     = $clog2(UC_LENGTH);

  typedef logic signed [LIT_W-1:0] lit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP  = 2'd1,
    FLUSH = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uc_lit_fifo.sv
// -----------------------------------------------------------------------------
// uc_lit_fifo
// Single-engine literal FIFO.
// Optional build macro: UC_DEDUP_EN -- when defined, a push whose literal
// matches any currently valid entry is dropped.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : push strobe (literal 0 is ignored)
//   push_lit    : literal to store
//   pop         : pop strobe (ignored when empty)
//   clear       : discard all entries; overrides push and pop
//   head        : oldest entry (valid only when !empty)
//   count       : number of stored entries
//   full, empty : status derived from the registered count
// -----------------------------------------------------------------------------
module uc_lit_fifo
  import uc_pkg::*;
#(
  parameter int LIT_W = uc_pkg::LIT_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [LIT_W-1:0]         push_lit,
  input  logic                     pop,
  input  logic                     clear,
  output logic [LIT_W-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [LIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dup;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem[rd_ptr_q];
  assign count = count_q;

`ifdef UC_DEDUP_EN
  // Only slots between the read pointer and read pointer + count hold live
  // data; stale slots must not suppress a push.
  logic [DEPTH-1:0] hit;
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    logic [PTR_W-1:0] offs;
    assign offs    = PTR_W'(gi) - rd_ptr_q;
    assign hit[gi] = ({1'b0, offs} < count_q) && (mem[gi] == push_lit);
  end
  assign dup = |hit;
`else
  assign dup = 1'b0;
`endif

  // A full FIFO still accepts a push when the head leaves in the same cycle;
  // the write lands in the slot being vacated.
  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & (|push_lit) & ~dup & (~full | do_pop) & ~clear;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; contents are only observed through count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_lit;
  end

endmodule

// File: rtl/uc_eng_tx.sv
// -----------------------------------------------------------------------------
// uc_eng_tx
// Engine-side transmitter toward the unit-clause arbiter. Buffers literals
// from NUM_ENGINE engines in per-engine FIFOs, answers a one-hot grant with a
// single-cycle response and flushes everything on conflict.
// Optional build macro: UC_DEDUP_EN (duplicate-literal suppression per FIFO).
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   eng_push       : per-engine push strobe
//   eng_lit        : per-engine literal, packed engine-major
//   eng_full       : per-engine FIFO full
//   engmask        : grant from arbiter, lowest set bit wins
//   conflict       : flush request
//   eng2uca_valid  : one-cycle response strobe
//   eng2uca_empty  : granted engine had nothing to send
//   eng2uca        : literal returned to the arbiter
//   busy           : any FIFO holds data
// -----------------------------------------------------------------------------
module uc_eng_tx #(
  parameter int NUM_ENGINE = 4,
  parameter int UC_LENGTH  = 512,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_ENGINE-1:0]                     eng_push,
  input  logic [NUM_ENGINE*$clog2(UC_LENGTH)-1:0]   eng_lit,
  output logic [NUM_ENGINE-1:0]                     eng_full,
  input  logic [NUM_ENGINE-1:0]                     engmask,
  input  logic                                      conflict,
  output logic                                      eng2uca_valid,
  output logic                                      eng2uca_empty,
  output logic [$clog2(UC_LENGTH)-1:0]              eng2uca,
  output logic                                      busy
);
  import uc_pkg::*;

  localparam int LIT_BITS = $clog2(UC_LENGTH);
  localparam int SEL_W    = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

  tx_state_e            state_q, state_d;
  logic                 valid_q, valid_d;
  logic                 empty_q, empty_d;
  logic [LIT_BITS-1:0]  lit_q, lit_d;

  logic [SEL_W-1:0]     sel;
  logic [NUM_ENGINE-1:0] pop_vec;
  logic                 flush;
  logic [NUM_ENGINE-1:0] fifo_empty;
  logic [NUM_ENGINE-1:0] fifo_full;
  logic [LIT_BITS-1:0]  head_arr  [NUM_ENGINE];
  logic [CNT_W-1:0]     count_arr [NUM_ENGINE];

  for (genvar gi = 0; gi < NUM_ENGINE; gi++) begin : g_fifo
    uc_lit_fifo #(
      .LIT_W (LIT_BITS),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (eng_push[gi]),
      .push_lit (eng_lit[gi*LIT_BITS +: LIT_BITS]),
      .pop      (pop_vec[gi]),
      .clear    (flush),
      .head     (head_arr[gi]),
      .count    (count_arr[gi]),
      .full     (fifo_full[gi]),
      .empty    (fifo_empty[gi])
    );
  end

  // Lowest set grant bit wins; scanning downward leaves the lowest index last.
  always_comb begin
    sel = '0;
    for (int i = NUM_ENGINE - 1; i >= 0; i--) begin
      if (engmask[i]) sel = SEL_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    pop_vec = '0;
    flush   = 1'b0;
    valid_d = 1'b0;
    empty_d = 1'b0;
    lit_d   = '0;
    case (state_q)
      IDLE: begin
        // Conflict outranks a simultaneous grant: nothing is popped.
        if (conflict) begin
          state_d = FLUSH;
        end else if (|engmask) begin
          pop_vec[sel] = 1'b1;
          valid_d      = 1'b1;
          empty_d      = fifo_empty[sel];
          lit_d        = fifo_empty[sel] ? '0 : head_arr[sel];
          state_d      = RESP;
        end
      end
      RESP: begin
        // The registered response is on the outputs now; grants are ignored.
        state_d = conflict ? FLUSH : IDLE;
      end
      FLUSH: begin
        flush   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      empty_q <= 1'b0;
      lit_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      empty_q <= empty_d;
      lit_q   <= lit_d;
    end
  end

  // Status comes from registered counts only; tie off unused count bits.
  logic [NUM_ENGINE-1:0] nonempty;
  for (genvar gi = 0; gi < NUM_ENGINE; gi++) begin : g_stat
    assign nonempty[gi] = (count_arr[gi] != '0);
  end

  assign eng_full      = fifo_full;
  assign busy          = |nonempty;
  assign eng2uca_valid = valid_q;
  assign eng2uca_empty = empty_q;
  assign eng2uca       = lit_q;

endmodule

// File: tb/tb_uc_eng_tx.sv
module tb_uc_eng_tx;

  localparam int NE = 4;
  localparam int LW = 9;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NE-1:0]   eng_push = '0;
  logic [NE*LW-1:0] eng_lit = '0;
  logic [NE-1:0]   eng_full;
  logic [NE-1:0]   engmask = '0;
  logic            conflict = 1'b0;
  logic            eng2uca_valid;
  logic            eng2uca_empty;
  logic [LW-1:0]   eng2uca;
  logic            busy;

  uc_eng_tx #(.NUM_ENGINE(NE), .UC_LENGTH(512), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .eng_push      (eng_push),
    .eng_lit       (eng_lit),
    .eng_full      (eng_full),
    .engmask       (engmask),
    .conflict      (conflict),
    .eng2uca_valid (eng2uca_valid),
    .eng2uca_empty (eng2uca_empty),
    .eng2uca       (eng2uca),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct { bit empty; logic [LW-1:0] lit; } resp_t;
  resp_t exp_q[$];

  // Reference model: ordered lists per engine plus two flags describing what
  // the previous clock edge committed the transmitter to.
  logic [LW-1:0] mdata [NE][DEPTH];
  int            mcnt  [NE];
  bit            m_in_resp = 0;
  bit            m_flush   = 0;

  function automatic void model_clear();
    for (int e = 0; e < NE; e++) mcnt[e] = 0;
    m_in_resp = 0;
    m_flush   = 0;
  endfunction

  function automatic void model_edge(input logic [NE-1:0] push,
                                     input logic [NE*LW-1:0] lits,
                                     input logic [NE-1:0] mask,
                                     input logic conf);
    logic [LW-1:0] pre [NE][DEPTH];
    int  pre_cnt [NE];
    bit  popped [NE];
    int  sel;
    resp_t r;
    for (int e = 0; e < NE; e++) begin
      pre_cnt[e] = mcnt[e];
      popped[e]  = 0;
      for (int k = 0; k < DEPTH; k++) pre[e][k] = mdata[e][k];
    end
    if (m_flush) begin
      for (int e = 0; e < NE; e++) mcnt[e] = 0;
      m_flush = 0;
      return;
    end
    if (m_in_resp) begin
      m_in_resp = 0;
      if (conf) m_flush = 1;
    end else if (conf) begin
      m_flush = 1;
    end else if (mask != 0) begin
      sel = 0;
      for (int e = NE - 1; e >= 0; e--) if (mask[e]) sel = e;
      if (mcnt[sel] == 0) begin
        r.empty = 1; r.lit = '0;
      end else begin
        r.empty = 0; r.lit = mdata[sel][0];
        for (int k = 0; k < DEPTH - 1; k++) mdata[sel][k] = mdata[sel][k+1];
        mcnt[sel]--;
        popped[sel] = 1;
      end
      exp_q.push_back(r);
      m_in_resp = 1;
    end
    for (int e = 0; e < NE; e++) begin
      logic [LW-1:0] l;
      bit dup;
      l = lits[e*LW +: LW];
      dup = 0;
`ifdef UC_DEDUP_EN
      for (int k = 0; k < pre_cnt[e]; k++) if (pre[e][k] == l) dup = 1;
`endif
      if (push[e] && l != 0 && !dup && (pre_cnt[e] < DEPTH || popped[e])) begin
        mdata[e][mcnt[e]] = l;
        mcnt[e]++;
      end
    end
  endfunction

  // One clock: drive at negedge, model follows the edge, status checked at
  // the next negedge.
  task automatic cycle(input logic [NE-1:0] push, input logic [NE*LW-1:0] lits,
                       input logic [NE-1:0] mask, input logic conf);
    logic [NE-1:0] exp_full;
    bit exp_busy;
    eng_push = push; eng_lit = lits; engmask = mask; conflict = conf;
    @(posedge clk);
    model_edge(push, lits, mask, conf);
    @(negedge clk);
    exp_full = '0; exp_busy = 0;
    for (int e = 0; e < NE; e++) begin
      exp_full[e] = (mcnt[e] == DEPTH);
      if (mcnt[e] != 0) exp_busy = 1;
    end
    n_vec++;
    if (eng_full !== exp_full) begin
      n_err++;
      $display("FAIL eng_full: got %b expected %b", eng_full, exp_full);
    end
    n_vec++;
    if (busy !== exp_busy) begin
      n_err++;
      $display("FAIL busy: got %b expected %b", busy, exp_busy);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, '0, 1'b0);
  endtask

  function automatic logic [NE*LW-1:0] lit_on(input int e, input int v);
    logic [NE*LW-1:0] x;
    x = '0;
    x[e*LW +: LW] = LW'(v);
    return x;
  endfunction

  task automatic push1(input int e, input int v);
    cycle(NE'(1) << e, lit_on(e, v), '0, 1'b0);
  endtask

  task automatic grant(input logic [NE-1:0] m);
    cycle('0, '0, m, 1'b0);
    idle(1);
  endtask

  task automatic check_all_zero(input string tag);
    n_vec++;
    if (eng2uca_valid !== 1'b0 || eng2uca_empty !== 1'b0 || eng2uca !== '0 ||
        eng_full !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got valid=%b empty=%b lit=%h full=%b busy=%b expected all 0",
               tag, eng2uca_valid, eng2uca_empty, eng2uca, eng_full, busy);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (eng2uca_valid === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL resp: got unexpected valid empty=%b lit=%h expected no response",
                   eng2uca_empty, eng2uca);
        end else begin
          resp_t r;
          r = exp_q.pop_front();
          if (eng2uca_empty !== r.empty || eng2uca !== r.lit) begin
            n_err++;
            $display("FAIL resp: got empty=%b lit=%h expected empty=%b lit=%h",
                     eng2uca_empty, eng2uca, r.empty, r.lit);
          end else begin
            $display("resp ok: empty=%b lit=%h", eng2uca_empty, eng2uca);
          end
        end
      end else begin
        n_vec++;
        if (eng2uca_valid !== 1'b0 || eng2uca_empty !== 1'b0 || eng2uca !== '0) begin
          n_err++;
          $display("FAIL idle_out: got valid=%b empty=%b lit=%h expected 0/0/0",
                   eng2uca_valid, eng2uca_empty, eng2uca);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Directed: one literal per engine, drained by shrinking grant masks.
    cycle(4'b1111, {9'h1FE, 9'd3, 9'd4, 9'd2}, '0, 1'b0);
    grant(4'b1111);
    grant(4'b1110);
    grant(4'b1100);
    grant(4'b1000);

    // Grant to an empty engine.
    grant(4'b0001);

    // Overfill engine 1; the fifth push is dropped.
    for (int v = 5; v <= 9; v++) push1(1, v);
    for (int i = 0; i < 5; i++) grant(4'b0010);

    // Push into full FIFO alongside a pop of that FIFO.
    push1(2, 10); push1(2, 12); push1(2, 13); push1(2, 14);
    cycle(4'b0100, lit_on(2, 11), 4'b0100, 1'b0);
    idle(1);
    for (int i = 0; i < 5; i++) grant(4'b0100);

    // Conflict coinciding with a grant flushes everything.
    cycle(4'b1111, {9'd21, 9'd22, 9'd23, 9'd24}, '0, 1'b0);
    cycle('0, '0, 4'b0001, 1'b1);
    idle(2);
    grant(4'b0001);

    // Conflict during a response: response completes, then flush.
    cycle(4'b0011, {9'd0, 9'd0, 9'd31, 9'd30}, '0, 1'b0);
    cycle('0, '0, 4'b0001, 1'b0);
    cycle('0, '0, '0, 1'b1);
    idle(2);

    // Duplicate literals to one engine.
    push1(0, 3); push1(0, 3); push1(0, -3);
    for (int i = 0; i < 4; i++) grant(4'b0001);

    // Literal 0 is ignored.
    push1(3, 0);
    grant(4'b1000);

    // Reset in the middle of a response window.
    cycle(4'b1111, {9'd41, 9'd42, 9'd43, 9'd44}, '0, 1'b0);
    eng_push = '0; eng_lit = '0; engmask = 4'b0001; conflict = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    engmask = '0;
    exp_q.delete();
    model_clear();
    @(negedge clk);
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    idle(1);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      logic [NE-1:0] p, m;
      logic [NE*LW-1:0] l;
      logic c;
      p = '0; l = '0; m = '0;
      for (int e = 0; e < NE; e++) begin
        int v;
        p[e] = ($urandom_range(0, 99) < 40);
        v = $urandom_range(0, 6);
        if ($urandom_range(0, 1) == 1) v = -v;
        l[e*LW +: LW] = LW'(v);
      end
      if ($urandom_range(0, 99) < 45) m = NE'($urandom_range(1, 15));
      c = ($urandom_range(0, 99) < 3);
      cycle(p, l, m, c);
    end

    idle(4);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending: got %0d responses missing expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uc_eng_tx.md
Name: uc_eng_tx

Overview:
- Engine-side transmitter toward uc_arbiter.
- Buffers unit-clause literals produced by NUM_ENGINE BCP engines in per-engine FIFOs.
- Responds to the arbiter's one-hot engmask grant by driving eng2uca_valid / eng2uca_empty / eng2uca.
- Flushes all pending literals when the arbiter raises conflict.

Parameters:
- NUM_ENGINE, 4, number of engines / FIFOs.
- UC_LENGTH, 512, literal space; LIT_W = $clog2(UC_LENGTH) = 9.
- FIFO_DEPTH, 4, entries per engine FIFO (equals UCQ_SIZE; power of 2, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- eng_push  in  NUM_ENGINE  per-engine push strobe.
- eng_lit  in  NUM_ENGINE×LIT_W  per-engine literal, two's complement; 0 is reserved.
- eng_full  out  NUM_ENGINE  FIFO full, registered.
- engmask  in  NUM_ENGINE  grant from arbiter; lowest set bit wins.
- conflict  in  1  arbiter conflict; flush request.
- eng2uca_valid  out  1  response valid, one-cycle pulse.
- eng2uca_empty  out  1  granted engine had nothing to send.
- eng2uca  out  LIT_W  literal to arbiter.
- busy  out  1  any FIFO non-empty.

Behaviour:
- Reset (async, rst_n=0): all FIFOs empty (pointers and counts 0), state=IDLE, eng2uca_valid=0, eng2uca_empty=0, eng2uca=0, eng_full=0, busy=0.
- FSM states:
  - IDLE: if conflict → FLUSH. Else if engmask≠0 → latch sel = index of lowest set bit, pop sel's head if non-empty → RESP.
  - RESP: outputs valid for exactly this cycle; engmask ignored. → IDLE, or FLUSH if conflict.
  - FLUSH: all FIFOs cleared at end of cycle; pushes this cycle dropped; outputs idle. → IDLE.
- Latency: grant sampled at clock edge N; eng2uca_valid=1 during cycle N+1 only. Back-to-back grants are served at most every 2 cycles.
- Response data:
  - Selected FIFO non-empty: eng2uca=head, eng2uca_empty=0.
  - Selected FIFO empty: eng2uca=0, eng2uca_empty=1.
  - eng2uca_valid=1 in both cases.
  - Outside RESP: valid=0, empty=0, eng2uca=0.
- Push rules:
  - Literal 0 is ignored.
  - Push into a full FIFO is dropped, except a push coinciding with a pop of the same FIFO, which is accepted (count unchanged).
  - Push and pop on an empty FIFO in the same cycle: the pop sees empty and returns empty=1; the push is stored.
- Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
- eng_full and busy are derived from registered counts (no same-cycle push visibility).
- conflict in the same cycle as a grant in IDLE: conflict wins, no pop, no response.
- conflict during RESP: the response still completes, then FLUSH.
- Reset mid-operation clears everything immediately; no response is issued.

Optional Feature:
- Macro: UC_DEDUP_EN.
- Defined: a push whose literal equals any valid entry in that engine's FIFO (combinational compare across FIFO_DEPTH entries) is dropped.
- Undefined: duplicates are stored; no compare logic is built.

Decomposition:
- Shared package uc_pkg holds:
  - LIT_W and UC_LENGTH constants.
  - typedef lit_t (logic signed [LIT_W-1:0]).
  - typedef tx_state_e {IDLE, RESP, FLUSH}.
- One sub-module uc_lit_fifo (single-engine FIFO: push, pop, clear, head, count, full, empty, plus dedup match under the macro), instantiated NUM_ENGINE times.

Test Plan:
- Reset, then push 2, 4, 3, -2 (0x1FE) to engines 0–3. Grant engmask=4'b1111, then 4'b1110, 4'b1100, 4'b1000 (2-cycle spacing) → responses 2, 4, 3, 0x1FE, each with valid=1 for one cycle and empty=0.
- Grant engmask=4'b0001 with engine 0 empty → valid=1, empty=1, eng2uca=0 one cycle after the grant.
- Push 5, 6, 7, 8, 9 to engine 1 → eng_full[1]=1 after 4 pushes, 9 dropped. Grants then return 5, 6, 7, 8, then empty=1.
- Engine 2 full with head 10, push 11 in the same cycle as grant 4'b0100 → response 10, 11 stored, eng_full[2] stays 1.
- FIFOs loaded, conflict=1 together with grant 4'b0001 → no valid pulse, busy=0 two cycles later, next grant returns empty=1.
- UC_DEDUP_EN defined, push 3, 3, -3 to engine 0 → two entries stored. Undefined → three entries stored.
